// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
package uart_pkg;

   // Default frame geometry: 8x oversampling, 8 data bits (8N1).
   localparam int OVERSAMPLE = 8;
   localparam int DATA_BITS  = 8;

   // Receiver FSM state encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte interface: data, one-cycle strobes and busy flag.
interface uart_rx_if #(
   parameter int DATA_BITS = uart_pkg::DATA_BITS
);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_done;
   logic                 frame_err;
   logic                 rx_busy;

   // The receiver drives the bus; the consumer only observes it.
   modport master (output rx_data, rx_done, frame_err, rx_busy);
   modport slave  (input  rx_data, rx_done, frame_err, rx_busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to idle (high).
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_s_o
);

   logic [1:0] sync_q;

   // Shift the raw line through two flops to settle metastability.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so both stages sample pre-edge values.
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], rx_i};
   end

   assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling on an oversampled baud tick.
module uart_rx #(
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
   parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      baud_tick,
   input  logic      rx,
   uart_rx_if.master rx_if
);

   import uart_pkg::*;

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TCNT_HALF   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TCNT_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BITCNT_LAST = BW'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q,     state_d;
   logic [TW-1:0]        tcnt_q,      tcnt_d;
   logic [BW-1:0]        bitcnt_q,    bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q,     shreg_d;
   logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
   logic                 rx_prev_q,   rx_prev_d;
   logic                 rx_done_q,   rx_done_d;
   logic                 frame_err_q, frame_err_d;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .rx_i   (rx),
      .rx_s_o (rx_s)
   );

   // State and datapath registers; a reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= '0;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_prev_q   <= 1'b1;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_prev_q   <= rx_prev_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic: everything advances on baud_tick except the strobes,
   // which fall back to zero on every clk.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      bitcnt_d    = bitcnt_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_prev_d   = rx_prev_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;

      if (baud_tick) begin
         rx_prev_d = rx_s;
         unique case (state_q)
            ST_IDLE: begin
               // Falling edge between consecutive ticks; a held-low line never matches.
               if (rx_prev_q && !rx_s) begin
                  state_d = ST_START;
                  tcnt_d  = '0;
               end
            end
            ST_START: begin
               if (tcnt_q == TCNT_HALF) begin
                  if (!rx_s) begin
                     state_d  = ST_DATA;
                     tcnt_d   = '0;
                     bitcnt_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            ST_DATA: begin
               if (tcnt_q == TCNT_LAST) begin
                  shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
                  tcnt_d   = '0;
                  bitcnt_d = bitcnt_q + BW'(1);
                  if (bitcnt_q == BITCNT_LAST) state_d = ST_STOP;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            ST_STOP: begin
               if (tcnt_q == TCNT_LAST) begin
                  if (rx_s) begin
                     rx_data_d = shreg_q;
                     rx_done_d = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
                  state_d = ST_IDLE;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign rx_if.rx_data   = rx_data_q;
   assign rx_if.rx_done   = rx_done_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.rx_busy   = (state_q != ST_IDLE);

endmodule
